// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-requester arbiter for the InstructionMem read port
module imem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_f_req_valid,
   output logic              io_f_req_ready,
   input  logic [ADDR_W-1:0] io_f_req_addr,
   output logic              io_f_resp_valid,
   input  logic              io_f_resp_ready,
   output logic [31:0]       io_f_resp_data,
   output logic              io_f_resp_err,
   input  logic              io_d_req_valid,
   output logic              io_d_req_ready,
   input  logic [ADDR_W-1:0] io_d_req_addr,
   output logic              io_d_resp_valid,
   input  logic              io_d_resp_ready,
   output logic [31:0]       io_d_resp_data,
   output logic              io_d_resp_err,
   output logic [ADDR_W-1:0] io_mem_addr,
   input  logic [31:0]       io_mem_data
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_F    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic [SW-1:0]     starve_q, starve_d;

   logic              f_owns, d_owns;
   logic              slot_free;
   logic              grant_f, grant_d;
   logic              f_acc, d_acc;
   logic [ADDR_W-1:0] gnt_addr;
   logic              gnt_misaligned, gnt_out_of_range;

   // Slot occupancy, priority grant and accept qualification
   always_comb begin
      f_owns    = (owner_q == OWN_F);
      d_owns    = (owner_q == OWN_D);
      // The slot frees in the same cycle the current response is consumed,
      // so a new request can issue back-to-back. Nothing is accepted in reset.
      slot_free = !reset &&
                  ((owner_q == OWN_NONE) ||
                   (f_owns && io_f_resp_ready) ||
                   (d_owns && io_d_resp_ready));
      // Debug normally wins a tie; fetch wins once it has been denied long enough
      grant_f   = io_f_req_valid &&
                  (!io_d_req_valid || (starve_q == SW'(STARVE_MAX)));
      grant_d   = io_d_req_valid && !grant_f;
      f_acc     = slot_free && grant_f;
      d_acc     = slot_free && grant_d;
      gnt_addr  = grant_f ? io_f_req_addr : io_d_req_addr;
      gnt_misaligned   = |gnt_addr[1:0];
      gnt_out_of_range = ({2'b00, gnt_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
   end

   // Next-state for owner, registered address, error flag and starvation count
   always_comb begin
      owner_d  = owner_q;
      addr_d   = addr_q;
      err_d    = err_q;
      starve_d = starve_q;

      if (f_acc || d_acc) begin
         owner_d = f_acc ? OWN_F : OWN_D;
         addr_d  = gnt_addr;
         err_d   = gnt_misaligned || gnt_out_of_range;
      end else if (slot_free) begin
         owner_d = OWN_NONE;
      end

      if (f_acc || !io_f_req_valid) begin
         starve_d = '0;
      end else if (slot_free && (starve_q != SW'(STARVE_MAX))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q  <= OWN_NONE;
         addr_q   <= '0;
         err_q    <= 1'b0;
         starve_q <= '0;
      end else begin
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
         starve_q <= starve_d;
      end
   end

   // Response and handshake outputs; errored accesses return zero data
   always_comb begin
      io_mem_addr     = addr_q;
      io_f_req_ready  = f_acc;
      io_d_req_ready  = d_acc;
      io_f_resp_valid = f_owns;
      io_d_resp_valid = d_owns;
      io_f_resp_data  = err_q ? 32'd0 : io_mem_data;
      io_d_resp_data  = err_q ? 32'd0 : io_mem_data;
      io_f_resp_err   = err_q;
      io_d_resp_err   = err_q;
   end

endmodule
